// File: rtl/regfile_dump_reader.sv
// ============================================================================
// Module   : regfile_dump_reader
// Brief    : Walks a register index range through one read port and streams
//            each value out on a valid/ready interface.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_dump_reader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] first_reg,
    input  logic [ADDR_W-1:0] last_reg,
    output logic [ADDR_W-1:0] read_reg,
    input  logic [DATA_W-1:0] read_data,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_reg,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_SEND = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W-1:0]   r_end;
    logic [DATA_W-1:0]   r_out_data;
    logic [ADDR_W-1:0]   r_out_reg;
    logic                r_out_valid;
    logic                r_out_last;
    logic                r_err;
    logic                w_accept;
    logic                w_reject;
    logic                w_handshake;
    logic                w_capture;

    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_handshake = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // abort outranks start even while idle
                if (start && !abort) begin
                    if (first_reg <= last_reg) begin
                        w_accept = 1'b1;
                        w_next   = S_READ;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            S_READ: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else begin
                    w_capture = 1'b1;
                    w_next    = S_SEND;
                end
            end
            S_SEND: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else if (out_ready) begin
                    w_handshake = 1'b1;
                    w_next      = (r_ptr == r_end) ? S_DONE : S_READ;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_end       <= '0;
            r_out_data  <= '0;
            r_out_reg   <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= w_reject;
            if (w_accept) begin
                r_ptr <= first_reg;
                r_end <= last_reg;
            end
            if (w_capture) begin
                r_out_data  <= read_data;
                r_out_reg   <= r_ptr;
                r_out_last  <= (r_ptr == r_end);
                r_out_valid <= 1'b1;
            end
            if (abort && r_state != S_IDLE) begin
                r_out_valid <= 1'b0;
            end
            if (w_handshake) begin
                r_out_valid <= 1'b0;
                // ptr stops at end, so the increment can never wrap
                if (r_ptr != r_end) begin
                    r_ptr <= r_ptr + 1'b1;
                end
            end
        end
    end

    assign read_reg  = r_ptr;
    assign out_data  = r_out_data;
    assign out_reg   = r_out_reg;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign err       = r_err;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE) && !abort;

endmodule

`default_nettype wire

// File: tb/tb_regfile_dump_reader.sv
// ============================================================================
// Module   : tb_regfile_dump_reader
// Brief    : Directed self-checking bench for regfile_dump_reader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_dump_reader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [4:0]  first_reg;
    logic [4:0]  last_reg;
    logic [4:0]  read_reg;
    logic [31:0] read_data;
    logic [31:0] out_data;
    logic [4:0]  out_reg;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        err;

    logic [31:0] regs [0:31];
    int          checks;
    int          errors;

    assign read_data = regs[read_reg];

    regfile_dump_reader #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .first_reg (first_reg),
        .last_reg  (last_reg),
        .read_reg  (read_reg),
        .read_data (read_data),
        .out_data  (out_data),
        .out_reg   (out_reg),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Start pulse sampled at the next edge; returns 1 ns into cycle t+1.
    task automatic do_start(input logic [4:0] f, input logic [4:0] l);
        first_reg = f;
        last_reg  = l;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({read_reg, out_data, out_reg, out_valid, out_last, busy, done, err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rr=%0d d=%h r=%0d v=%b l=%b b=%b dn=%b e=%b, want all 0",
                     read_reg, out_data, out_reg, out_valid, out_last, busy, done, err);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_full_dump();
        bit   exp_v;
        bit   exp_l;
        int   k;
        out_ready = 1'b1;
        do_start(5'd0, 5'd31);
        for (int c = 1; c <= 67; c++) begin
            exp_v = (c % 2 == 0) && (c >= 2) && (c <= 64);
            k     = (c - 2) / 2;
            exp_l = exp_v && (k == 31);
            checks++;
            if (out_valid !== exp_v || busy !== (c <= 65) || done !== (c == 65)) begin
                errors++;
                $display("FAIL full_ctrl c=%0d: v=%b b=%b dn=%b want v=%b b=%b dn=%b",
                         c, out_valid, busy, done, exp_v, (c <= 65), (c == 65));
            end
            if (exp_v) begin
                checks++;
                if (out_reg !== 5'(k) || out_data !== 32'h1000_0000 + k || out_last !== exp_l) begin
                    errors++;
                    $display("FAIL full_word k=%0d: r=%0d d=%h l=%b want r=%0d d=%h l=%b",
                             k, out_reg, out_data, out_last, k, 32'h1000_0000 + k, exp_l);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int          words;
        int          stall;
        int          dones;
        int          budget;
        logic [31:0] h_data;
        logic [4:0]  h_reg;
        logic        h_last;
        words  = 0;
        stall  = 0;
        dones  = 0;
        budget = 0;
        out_ready = 1'b0;
        do_start(5'd4, 5'd6);
        while (dones == 0 && budget < 100) begin
            if (done) dones++;
            if (out_valid) begin
                if (stall == 0) begin
                    h_data = out_data;
                    h_reg  = out_reg;
                    h_last = out_last;
                    checks++;
                    if (out_reg !== 5'(4 + words) || out_data !== 32'h1000_0004 + words ||
                        out_last !== (words == 2)) begin
                        errors++;
                        $display("FAIL bp_word %0d: r=%0d d=%h l=%b want r=%0d d=%h l=%b",
                                 words, out_reg, out_data, out_last, 4 + words,
                                 32'h1000_0004 + words, (words == 2));
                    end
                end else begin
                    checks++;
                    if (out_data !== h_data || out_reg !== h_reg || out_last !== h_last) begin
                        errors++;
                        $display("FAIL bp_stable: r=%0d d=%h l=%b want held r=%0d d=%h l=%b",
                                 out_reg, out_data, out_last, h_reg, h_data, h_last);
                    end
                end
                if (stall < 5) begin
                    out_ready = 1'b0;
                    stall++;
                end else begin
                    out_ready = 1'b1;
                    words++;
                    stall = 0;
                end
            end else begin
                out_ready = 1'b0;
            end
            budget++;
            @(posedge clk); #1;
        end
        repeat (3) begin
            if (done) dones++;
            @(posedge clk); #1;
        end
        checks++;
        if (words !== 3 || dones !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_totals: words=%0d dones=%0d busy=%b want 3 1 0", words, dones, busy);
        end
    endtask

    task automatic test_single();
        regs[7]   = 32'hDEAD_BEEF;
        out_ready = 1'b1;
        do_start(5'd7, 5'd7);
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_reg !== 5'd7 || out_data !== 32'hDEAD_BEEF || out_last !== 1'b1) begin
            errors++;
            $display("FAIL single_word: v=%b r=%0d d=%h l=%b want 1 7 deadbeef 1",
                     out_valid, out_reg, out_data, out_last);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_done: dn=%b v=%b want 1 0", done, out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_after: dn=%b b=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_invalid_and_busy_start();
        int words;
        int dones;
        int errs;
        do_start(5'd9, 5'd3);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL inv_err: e=%b b=%b v=%b want 1 0 0", err, busy, out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL inv_pulse: e=%b b=%b want 0 0", err, busy);
        end
        abort = 1'b1;
        do_start(5'd1, 5'd2);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL idle_abort_prio: b=%b e=%b want 0 0", busy, err);
        end
        out_ready = 1'b1;
        words = 0;
        dones = 0;
        errs  = 0;
        do_start(5'd0, 5'd3);
        for (int c = 1; c <= 14; c++) begin
            if (c == 3) begin
                first_reg = 5'd10;
                last_reg  = 5'd12;
                start     = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (out_valid) begin
                checks++;
                if (out_reg !== 5'(words)) begin
                    errors++;
                    $display("FAIL busy_start_seq: r=%0d want %0d", out_reg, words);
                end
                words++;
            end
            if (done) dones++;
            if (err) errs++;
            @(posedge clk); #1;
        end
        checks++;
        if (words !== 4 || dones !== 1 || errs !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_start_totals: words=%0d dones=%0d errs=%0d busy=%b want 4 1 0 0",
                     words, dones, errs, busy);
        end
    endtask

    task automatic test_abort();
        int seen;
        out_ready = 1'b1;
        do_start(5'd0, 5'd7);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_reg !== 5'd2) begin
            errors++;
            $display("FAIL abort_pre: v=%b r=%0d want 1 2", out_valid, out_reg);
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: v=%b b=%b dn=%b want 0 0 0", out_valid, busy, done);
        end
        seen = 0;
        repeat (4) begin
            if (done || out_valid || busy) seen++;
            @(posedge clk); #1;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort_quiet: activity=%0d want 0", seen);
        end
        do_start(5'd0, 5'd7);
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_reg !== 5'd0 || out_data !== 32'h1000_0000) begin
            errors++;
            $display("FAIL abort_restart: v=%b r=%0d d=%h want 1 0 10000000",
                     out_valid, out_reg, out_data);
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
    endtask

    task automatic test_reset_mid_dump();
        out_ready = 1'b1;
        do_start(5'd5, 5'd31);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if ({read_reg, out_data, out_reg, out_valid, out_last, busy, done, err} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: rr=%0d d=%h r=%0d v=%b l=%b b=%b dn=%b e=%b want all 0",
                     read_reg, out_data, out_reg, out_valid, out_last, busy, done, err);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_idle: b=%b dn=%b v=%b want 0 0 0", busy, done, out_valid);
        end
        do_start(5'd2, 5'd3);
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_reg !== 5'd2 || out_data !== 32'h1000_0002 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL midreset_restart w0: v=%b r=%0d d=%h l=%b want 1 2 10000002 0",
                     out_valid, out_reg, out_data, out_last);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_reg !== 5'd3 || out_last !== 1'b1) begin
            errors++;
            $display("FAIL midreset_restart w1: v=%b r=%0d l=%b want 1 3 1", out_valid, out_reg, out_last);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL midreset_done: dn=%b want 1", done);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        first_reg = '0;
        last_reg  = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + i;
        test_reset();
        test_full_dump();
        test_backpressure();
        test_single();
        test_invalid_and_busy_start();
        test_abort();
        test_reset_mid_dump();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
